mlaccel_qspi_responder: RTL
===========================

Name: mlaccel_qspi_responder

Overview:
- QSPI target on the mlaccel side of the shared flash/ml bus, opposite end of the controller's bit-banged ml_csb/flash_clk/io[3:0] link.
- Decodes nibble-wide command frames and turns them into byte accesses on an internal buffer port.
- Also returns a status byte.
- The controller drives SCLK far slower than clk, so all pins are oversampled through synchronizers and processed in the clk domain.

Parameters:
ADDR_W, 16, buffer byte-address width (address phase is always 16 bits; upper bits truncated when ADDR_W<16)
SYNC_STAGES, 2, synchronizer depth on sclk/csb/io inputs

Ports:
clk  in  1  system clock
resetn  in  1  reset, synchronous, active-low
spi_sclk  in  1  serial clock from controller, idle low
spi_csb  in  1  chip select, active low
spi_io_di  in  4  io3..io0 pin inputs
spi_io_do  out  4  io3..io0 drive values
spi_io_oe  out  4  io3..io0 output enables
mem_addr  out  ADDR_W  buffer byte address
mem_wen  out  1  one-cycle write strobe
mem_wdata  out  8  write byte
mem_ren  out  1  one-cycle read strobe
mem_rdata  in  8  read byte, valid exactly 1 clk after mem_ren
status_in  in  8  status byte sampled for STATUS command
frame_err  out  1  sticky error; cleared at next csb falling edge

Behaviour:
- Reset: spi_io_oe=0, spi_io_do=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0, frame_err=0, state=IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals.
- Bus timing: controller-side SCLK high and low phases are each ≥4 clk cycles.
- Nibble order: MSB nibble first, io3 = MSB of the nibble. Target samples io on SCLK rising edge and updates spi_io_do on SCLK falling edge.
- csb high (synchronized) at any time: abort the frame, oe=0, state=IDLE, no further mem strobes. A partial byte is discarded.
- csb falling edge: frame_err<=0, state=CMD, nibble counter=0.
- States:
  - IDLE: wait for csb falling edge.
  - CMD: 2 nibbles form the command byte.
    - 0x01 goes to WADDR.
    - 0x02 goes to RADDR.
    - 0x05 goes to STAT_DUMMY.
    - Any other value: frame_err<=1, go to IGNORE.
  - WADDR/RADDR: 4 nibbles form a 16-bit address; load mem_addr. WADDR then goes to WDATA; RADDR goes to RDUMMY.
  - WDATA: each 2 nibbles form a byte.
    - On the rising edge that completes the byte, pulse mem_wen for 1 cycle with mem_wdata.
    - mem_addr increments (mod 2^ADDR_W) the cycle after mem_wen.
    - Unlimited bytes per frame.
  - RDUMMY: 2 SCLK cycles (turnaround).
    - mem_ren pulses on the rising edge that completes the 4th address nibble.
    - The fetched byte is held in a shift register.
    - After the 2nd dummy rising edge, set oe=4'b1111 and present the high nibble on the following falling edge.
  - RDATA: on each falling edge, output the next nibble (high then low).
    - When the low nibble is presented, increment mem_addr and pulse mem_ren. The next byte is captured before the next falling edge (guaranteed by the ≥4-clk phase rule).
    - Wraps mod 2^ADDR_W.
  - STAT_DUMMY: 2 SCLK cycles, then behaves like RDATA with a single byte, status_in latched at entry.
    - After the 2 nibbles: oe=0, go to IGNORE.
  - IGNORE: oe=0, no strobes, until csb high.
- mem_wen and mem_ren are never asserted in the same cycle.
- SCLK edges while csb is high are ignored.
- Simultaneous csb rise and SCLK edge: csb wins; the edge is discarded.
- Reset mid-frame: return to the reset state immediately. The remaining frame is ignored until the next csb falling edge.

Decomposition:
- Package mlaccel_qspi_pkg:
  - Command constants: CMD_WRITE=8'h01, CMD_READ=8'h02, CMD_STATUS=8'h05.
  - State enum: IDLE, CMD, WADDR, RADDR, WDATA, RDUMMY, RDATA, STAT_DUMMY, IGNORE.
  - DUMMY_CYCLES=2.
- Sub-module mlaccel_qspi_sync: synchronizer plus edge detector for sclk/csb and io capture. Outputs sclk_rise, sclk_fall, csb_q, csb_fall, io_q.

Test Plan:
- Write frame: cmd 01, addr 0x0010, bytes A5 3C → mem_wen ×2 with (0x0010,A5), (0x0011,3C); frame_err=0; oe stays 0.
- Read frame: cmd 02, addr 0x00FE, memory model returns 0x12 at 0xFE and 0x34 at 0xFF.
  - After 2 dummy clocks, the controller samples nibbles 1,2,3,4 on rising edges.
  - oe=1111 only after the dummy phase.
- Address wrap: write at 0xFFFF with 2 bytes → second write goes to addr 0x0000.
- Status: status_in=0x81, cmd 05 plus 2 dummy clocks → nibbles 8,1 returned, then oe=0.
- Bad command 0x7E followed by 6 nibbles → frame_err=1, no mem strobes, oe=0. Next csb falling edge clears frame_err.
- Abort and reset: csb raised after 1 data nibble of a write → no mem_wen. resetn low mid-read → oe=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/mlaccel_qspi_pkg.sv
// Shared constants and types for the mlaccel QSPI responder.
package mlaccel_qspi_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    localparam int unsigned DUMMY_CYCLES = 2;
    localparam int unsigned NIB_W        = 4;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        WADDR,
        RADDR,
        WDATA,
        RDUMMY,
        RDATA,
        STAT_DUMMY,
        IGNORE
    } state_e;

    // Append a freshly sampled nibble below the bits already collected.
    function automatic logic [15:0] shift_nibble(input logic [11:0] w, input logic [NIB_W-1:0] n);
        return {w, n};
    endfunction

endpackage

// File: rtl/mlaccel_qspi_sync.sv
// Pin synchronizer and edge detector for the QSPI sclk/csb/io inputs.
module mlaccel_qspi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_sclk,
    input  logic       spi_csb,
    input  logic [3:0] spi_io_di,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       csb_q,
    output logic       csb_fall,
    output logic [3:0] io_q
);

    localparam int unsigned LAST = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0]      sclk_sh_q, sclk_sh_d;
    logic [SYNC_STAGES-1:0]      csb_sh_q, csb_sh_d;
    logic [SYNC_STAGES-1:0][3:0] io_sh_q, io_sh_d;
    logic                        sclk_prev_q, sclk_prev_d;
    logic                        csb_prev_q, csb_prev_d;
    logic                        sclk_rise_q, sclk_rise_d;
    logic                        sclk_fall_q, sclk_fall_d;
    logic                        csb_d;
    logic                        csb_fall_q, csb_fall_d;
    logic [3:0]                  io_d;

    // csb stages reset low so a frame already in flight at reset release never looks like a new falling edge.
    always_comb begin
        sclk_sh_d[0] = spi_sclk;
        csb_sh_d[0]  = spi_csb;
        io_sh_d[0]   = spi_io_di;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sclk_sh_d[i] = sclk_sh_q[i-1];
            csb_sh_d[i]  = csb_sh_q[i-1];
            io_sh_d[i]   = io_sh_q[i-1];
        end
        sclk_prev_d = sclk_sh_q[LAST];
        csb_prev_d  = csb_sh_q[LAST];
        sclk_rise_d = sclk_sh_q[LAST] & ~sclk_prev_q;
        sclk_fall_d = ~sclk_sh_q[LAST] & sclk_prev_q;
        csb_d       = csb_sh_q[LAST];
        csb_fall_d  = ~csb_sh_q[LAST] & csb_prev_q;
        io_d        = io_sh_q[LAST];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_sh_q   <= '0;
            csb_sh_q    <= '0;
            io_sh_q     <= '0;
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            csb_q       <= 1'b1;
            csb_fall_q  <= 1'b0;
            io_q        <= 4'h0;
        end else begin
            sclk_sh_q   <= sclk_sh_d;
            csb_sh_q    <= csb_sh_d;
            io_sh_q     <= io_sh_d;
            sclk_prev_q <= sclk_prev_d;
            csb_prev_q  <= csb_prev_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            csb_q       <= csb_d;
            csb_fall_q  <= csb_fall_d;
            io_q        <= io_d;
        end
    end

    assign sclk_rise = sclk_rise_q;
    assign sclk_fall = sclk_fall_q;
    assign csb_fall  = csb_fall_q;

endmodule

// File: rtl/mlaccel_qspi_responder.sv
// QSPI target: decodes nibble-wide command frames into byte accesses on a buffer port.
module mlaccel_qspi_responder
    import mlaccel_qspi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_sclk,
    input  logic              spi_csb,
    input  logic [3:0]        spi_io_di,
    output logic [3:0]        spi_io_do,
    output logic [3:0]        spi_io_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [7:0]        mem_wdata,
    output logic              mem_ren,
    input  logic [7:0]        mem_rdata,
    input  logic [7:0]        status_in,
    output logic              frame_err
);

    logic       sclk_rise, sclk_fall, csb_s, csb_fall;
    logic [3:0] io_s;

    mlaccel_qspi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .spi_sclk (spi_sclk),
        .spi_csb  (spi_csb),
        .spi_io_di(spi_io_di),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .csb_q    (csb_s),
        .csb_fall (csb_fall),
        .io_q     (io_s)
    );

    state_e            state_q, state_d;
    logic [1:0]        nib_cnt_q, nib_cnt_d;
    logic [11:0]       shreg_q, shreg_d;
    logic [15:0]       nib_word;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic              mem_ren_q, mem_ren_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        tx_q, tx_d;
    logic              tx_lo_q, tx_lo_d;
    logic              is_stat_q, is_stat_d;
    logic              stat_done_q, stat_done_d;
    logic [3:0]        io_do_q, io_do_d;
    logic [3:0]        io_oe_q, io_oe_d;
    logic              frame_err_q, frame_err_d;

    assign nib_word = shift_nibble(shreg_q, io_s);

    always_comb begin
        state_d     = state_q;
        nib_cnt_d   = nib_cnt_q;
        shreg_d     = shreg_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        rd_pend_d   = mem_ren_q;
        mem_wdata_d = mem_wdata_q;
        tx_d        = tx_q;
        tx_lo_d     = tx_lo_q;
        is_stat_d   = is_stat_q;
        stat_done_d = stat_done_q;
        io_do_d     = io_do_q;
        io_oe_d     = io_oe_q;
        frame_err_d = frame_err_q;

        if (mem_wen_q) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
        // Read data returns one cycle after the strobe; park it for the next falling edge.
        if (rd_pend_q) begin
            tx_d = mem_rdata;
        end

        if (csb_s) begin
            state_d = IDLE;
            io_oe_d = 4'h0;
        end else if (csb_fall) begin
            state_d     = CMD;
            nib_cnt_d   = 2'd0;
            frame_err_d = 1'b0;
            io_oe_d     = 4'h0;
        end else begin
            case (state_q)
                CMD: begin
                    if (sclk_rise) begin
                        shreg_d = nib_word[11:0];
                        if (nib_cnt_q == 2'd1) begin
                            nib_cnt_d = 2'd0;
                            case (nib_word[7:0])
                                CMD_WRITE:  state_d = WADDR;
                                CMD_READ:   state_d = RADDR;
                                CMD_STATUS: begin
                                    state_d   = STAT_DUMMY;
                                    tx_d      = status_in;
                                    is_stat_d = 1'b1;
                                end
                                default: begin
                                    state_d     = IGNORE;
                                    frame_err_d = 1'b1;
                                end
                            endcase
                        end else begin
                            nib_cnt_d = nib_cnt_q + 2'd1;
                        end
                    end
                end
                WADDR, RADDR: begin
                    if (sclk_rise) begin
                        shreg_d = nib_word[11:0];
                        if (nib_cnt_q == 2'd3) begin
                            nib_cnt_d  = 2'd0;
                            mem_addr_d = ADDR_W'(nib_word);
                            if (state_q == WADDR) begin
                                state_d = WDATA;
                            end else begin
                                state_d   = RDUMMY;
                                mem_ren_d = 1'b1;
                                is_stat_d = 1'b0;
                            end
                        end else begin
                            nib_cnt_d = nib_cnt_q + 2'd1;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shreg_d = nib_word[11:0];
                        if (nib_cnt_q == 2'd1) begin
                            nib_cnt_d   = 2'd0;
                            mem_wen_d   = 1'b1;
                            mem_wdata_d = nib_word[7:0];
                        end else begin
                            nib_cnt_d = 2'd1;
                        end
                    end
                end
                RDUMMY, STAT_DUMMY: begin
                    if (sclk_rise) begin
                        if (nib_cnt_q == 2'(DUMMY_CYCLES - 1)) begin
                            nib_cnt_d   = 2'd0;
                            io_oe_d     = 4'hF;
                            tx_lo_d     = 1'b0;
                            stat_done_d = 1'b0;
                            state_d     = RDATA;
                        end else begin
                            nib_cnt_d = nib_cnt_q + 2'd1;
                        end
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        if (stat_done_q) begin
                            io_oe_d = 4'h0;
                            state_d = IGNORE;
                        end else if (!tx_lo_q) begin
                            io_do_d = tx_q[7:4];
                            tx_lo_d = 1'b1;
                        end else begin
                            io_do_d = tx_q[3:0];
                            tx_lo_d = 1'b0;
                            if (is_stat_q) begin
                                stat_done_d = 1'b1;
                            end else begin
                                mem_addr_d = mem_addr_q + ADDR_W'(1);
                                mem_ren_d  = 1'b1;
                            end
                        end
                    end
                end
                IGNORE: io_oe_d = 4'h0;
                IDLE:   ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            nib_cnt_q   <= 2'd0;
            shreg_q     <= '0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            mem_wdata_q <= 8'h00;
            tx_q        <= 8'h00;
            tx_lo_q     <= 1'b0;
            is_stat_q   <= 1'b0;
            stat_done_q <= 1'b0;
            io_do_q     <= 4'h0;
            io_oe_q     <= 4'h0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_cnt_q   <= nib_cnt_d;
            shreg_q     <= shreg_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            rd_pend_q   <= rd_pend_d;
            mem_wdata_q <= mem_wdata_d;
            tx_q        <= tx_d;
            tx_lo_q     <= tx_lo_d;
            is_stat_q   <= is_stat_d;
            stat_done_q <= stat_done_d;
            io_do_q     <= io_do_d;
            io_oe_q     <= io_oe_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_io_do = io_do_q;
    assign spi_io_oe = io_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ren   = mem_ren_q;
    assign frame_err = frame_err_q;

endmodule
